rf_writeback: RTL and testbench

Write-back stage that owns the single write port of the 32x32 register file. Merges ALU results (valid/ready) and in-order load responses (tracked in a pending-load queue), aligns and sign-extends load data, and drives the registered write port. Exposes per-operand busy flags so issue logic can stall on outstanding loads.

---
 rtl/rf_wb_pkg.sv | 23 ++
 rtl/rf_wb_load_align.sv | 28 ++
 rtl/rf_writeback.sv | 167 ++++++++++++++++
 tb/tb_rf_writeback.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back stage: load width
// codes, the pending-load queue entry layout and a pointer-width helper.
package rf_wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // One outstanding load: where it writes, how wide it is, and its byte offset.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } ldEntry_t;

    // Index width for a queue of 'depth' entries; never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_load_align.sv
// Load data alignment: shift the returned word down to the addressed byte,
// then truncate and sign- or zero-extend according to the load width code.
// Misaligned offsets are not trapped; the shifted word is simply truncated.
module rf_wb_load_align
    import rf_wb_pkg::*;
(
    input  logic [31:0] rspData_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Shift by the byte offset, then extend the selected width to a full word.
    always_comb begin
        shifted = rspData_i >> {off_i, 3'b000};
        case (funct3_i)
            LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     data_o = {24'h000000, shifted[7:0]};
            LHU:     data_o = {16'h0000, shifted[15:0]};
            LW:      data_o = shifted;
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// Write-back stage owning the single register-file write port. Merges ALU
// results with in-order load responses tracked in a pending-load queue and
// drives a registered write port. Responses always win the port; the ALU is
// held off while a queued load targets the same register so writes to one
// register land in program order.
// Optional feature macro: RF_WB_BYPASS_EN -- forwards the value sitting in
// the write-port register to the issue stage instead of reporting it busy.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            wr_en_o,
    output logic [4:0]      wr_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic            rsp_orphan_o,
    output logic            rs1_fwd_o,
    output logic            rs2_fwd_o,
    output logic [XLEN-1:0] fwd_data_o
);

    localparam int AW = ptrWidth(DEPTH);

    ldEntry_t        entries_q [DEPTH];
    logic [AW:0]     wrPtr_q, wrPtr_d;
    logic [AW:0]     rdPtr_q, rdPtr_d;
    logic [AW:0]     count;
    logic [DEPTH-1:0] occupied;
    logic            empty, full;
    logic            enq, retire, aluFire;
    ldEntry_t        head;
    logic [XLEN-1:0] loadData;
    logic            rs1Queued, rs2Queued, aluQueued;

    logic            wrEn_q, wrEn_d;
    logic [4:0]      wrAddr_q, wrAddr_d;
    logic [XLEN-1:0] wrData_q, wrData_d;
    logic            orphan_q, orphan_d;

    // The extra pointer bit distinguishes a full queue from an empty one.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A same-cycle response cannot make room for this cycle's issue, and a
    // response only retires an entry that was already queued.
    assign ld_ready_o = !full;
    assign enq        = ld_valid_i && !full;
    assign retire     = rsp_valid_i && !empty;
    assign head       = entries_q[rdPtr_q[AW-1:0]];

    rf_wb_load_align u_align (
        .rspData_i (rsp_data_i),
        .funct3_i  (head.funct3),
        .off_i     (head.off),
        .data_o    (loadData)
    );

    // Mark which physical slots currently hold live entries.
    always_comb begin
        occupied = '0;
        count    = wrPtr_q - rdPtr_q;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = {1'b0, AW'(i) - rdPtr_q[AW-1:0]} < count;
        end
    end

    // Compare every live entry against the operand and ALU destinations.
    always_comb begin
        rs1Queued = 1'b0;
        rs2Queued = 1'b0;
        aluQueued = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i]) begin
                if (entries_q[i].rd == rs1_i)    rs1Queued = 1'b1;
                if (entries_q[i].rd == rs2_i)    rs2Queued = 1'b1;
                if (entries_q[i].rd == alu_rd_i) aluQueued = 1'b1;
            end
        end
    end

    assign alu_ready_o = !rsp_valid_i && !((alu_rd_i != 5'd0) && aluQueued);
    assign aluFire     = alu_valid_i && alu_ready_o;

    // Select the next write: a retiring load first, otherwise an accepted ALU result.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        orphan_d = rsp_valid_i && empty;
        rdPtr_d  = rdPtr_q + {{AW{1'b0}}, retire};
        wrPtr_d  = wrPtr_q + {{AW{1'b0}}, enq};
        if (retire) begin
            wrEn_d   = (head.rd != 5'd0);
            wrAddr_d = head.rd;
            wrData_d = loadData;
        end else if (aluFire) begin
            wrEn_d   = (alu_rd_i != 5'd0);
            wrAddr_d = alu_rd_i;
            wrData_d = alu_data_i;
        end
    end

    // Pointers, write port and orphan flag; reset flushes all pending loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= 5'd0;
            wrData_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            orphan_q <= orphan_d;
        end
    end

    // Queue payload storage; liveness is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        if (enq) begin
            entries_q[wrPtr_q[AW-1:0]] <= '{rd: ld_rd_i, funct3: ld_funct3_i, off: ld_off_i};
        end
    end

    assign wr_en_o      = wrEn_q;
    assign wr_addr_o    = wrAddr_q;
    assign wr_data_o    = wrData_q;
    assign rsp_orphan_o = orphan_q;

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd_o  = wrEn_q && (wrAddr_q == rs1_i) && (rs1_i != 5'd0);
    assign rs2_fwd_o  = wrEn_q && (wrAddr_q == rs2_i) && (rs2_i != 5'd0);
    assign fwd_data_o = wrData_q;
    assign rs1_busy_o = (rs1_i != 5'd0) && rs1Queued;
    assign rs2_busy_o = (rs2_i != 5'd0) && rs2Queued;
`else
    assign rs1_fwd_o  = 1'b0;
    assign rs2_fwd_o  = 1'b0;
    assign fwd_data_o = '0;
    assign rs1_busy_o = (rs1_i != 5'd0) && (rs1Queued || (wrEn_q && (wrAddr_q == rs1_i)));
    assign rs2_busy_o = (rs2_i != 5'd0) && (rs2Queued || (wrEn_q && (wrAddr_q == rs2_i)));
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: a cycle-by-cycle vector table plus
// hand-written sequences for reset flush and the write-stage bypass.
module tb_rf_writeback;
    import rf_wb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        aluValid, aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldValid, ldReady;
    logic [4:0]  ldRd;
    logic [2:0]  ldFunct3;
    logic [1:0]  ldOff;
    logic        rspValid;
    logic [31:0] rspData;
    logic [4:0]  rs1, rs2;
    logic        rs1Busy, rs2Busy;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        rspOrphan;
    logic        rs1Fwd, rs2Fwd;
    logic [31:0] fwdData;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        aluV;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        ldV;
        logic [4:0]  ldRd;
        logic [2:0]  ldF3;
        logic [1:0]  ldOff;
        logic        rspV;
        logic [31:0] rspData;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        eLdRdy;
        logic        eAluRdy;
        logic        eQ1;
        logic        eQ2;
        logic        eWrEn;
        logic [4:0]  eWrAddr;
        logic [31:0] eWrData;
        logic        eOrph;
    } vec_t;

    vec_t vecs[$];

    rf_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid_i  (aluValid),
        .alu_ready_o  (aluReady),
        .alu_rd_i     (aluRd),
        .alu_data_i   (aluData),
        .ld_valid_i   (ldValid),
        .ld_ready_o   (ldReady),
        .ld_rd_i      (ldRd),
        .ld_funct3_i  (ldFunct3),
        .ld_off_i     (ldOff),
        .rsp_valid_i  (rspValid),
        .rsp_data_i   (rspData),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rs1_busy_o   (rs1Busy),
        .rs2_busy_o   (rs2Busy),
        .wr_en_o      (wrEn),
        .wr_addr_o    (wrAddr),
        .wr_data_o    (wrData),
        .rsp_orphan_o (rspOrphan),
        .rs1_fwd_o    (rs1Fwd),
        .rs2_fwd_o    (rs2Fwd),
        .fwd_data_o   (fwdData)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    function automatic vec_t mkVec(
        input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
        input logic lV, input logic [4:0] lRd, input logic [2:0] lF3, input logic [1:0] lOff,
        input logic rV, input logic [31:0] rD,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic eLr, input logic eAr, input logic eQ1, input logic eQ2,
        input logic eWe, input logic [4:0] eWa, input logic [31:0] eWd, input logic eOr);
        vec_t v;
        v.aluV = aV;  v.aluRd = aRd; v.aluData = aD;
        v.ldV = lV;   v.ldRd = lRd;  v.ldF3 = lF3; v.ldOff = lOff;
        v.rspV = rV;  v.rspData = rD;
        v.rs1 = r1;   v.rs2 = r2;
        v.eLdRdy = eLr; v.eAluRdy = eAr; v.eQ1 = eQ1; v.eQ2 = eQ2;
        v.eWrEn = eWe;  v.eWrAddr = eWa; v.eWrData = eWd; v.eOrph = eOr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        aluValid = v.aluV;  aluRd = v.aluRd;  aluData = v.aluData;
        ldValid  = v.ldV;   ldRd  = v.ldRd;   ldFunct3 = v.ldF3; ldOff = v.ldOff;
        rspValid = v.rspV;  rspData = v.rspData;
        rs1 = v.rs1;        rs2 = v.rs2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t idleVec(input logic [4:0] r1, input logic [4:0] r2);
        return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        logic eBusy1, eBusy2, eFwd1, eFwd2;

        // Each vector: inputs driven this cycle, outputs expected in this cycle
        // (registered outputs reflect what was accepted on the previous edge).
        // LB x5 off=1, response 0x8000 -> 0xFFFFFF80
        vecs.push_back(mkVec(0, 0, 0, 1, 5, LB, 1, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_8000, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 1, 5, 32'hFFFF_FF80, 0));
        vecs.push_back(idleVec(5, 0));
        // ALU x3 collides with a response: load writes first, ALU next
        vecs.push_back(mkVec(0, 0, 0, 1, 6, LW, 0, 0, 0, 3, 6, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 3, 32'h1234, 0, 0, 0, 0, 1, 32'hCAFE_BABE, 3, 6, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 3, 6, 1, 1, 0, 0, 1, 6, 32'hCAFE_BABE, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 6, 1, 1, 0, 0, 1, 3, 32'h0000_1234, 0));
        // Fill the queue, then issue+response while full
        vecs.push_back(mkVec(0, 0, 0, 1, 10, LH, 2, 0, 0, 10, 13, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 11, LBU, 3, 0, 0, 10, 13, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 12, LHU, 0, 0, 0, 10, 13, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 13, 3'b011, 1, 0, 0, 10, 13, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 14, LB, 0, 1, 32'h8001_7F00, 10, 13, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 14, LB, 0, 0, 0, 10, 14, 1, 1, 0, 0, 1, 10, 32'hFFFF_8001, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hF100_0000, 11, 14, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_F0F0, 11, 12, 1, 0, 0, 1, 1, 11, 32'h0000_00F1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hAABB_CCDD, 13, 12, 1, 0, 1, 0, 1, 12, 32'h0000_F0F0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_567F, 14, 0, 1, 0, 1, 0, 1, 13, 32'h00AA_BBCC, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 0, 1, 1, 0, 0, 1, 14, 32'h0000_007F, 0));
        // WAW: ALU x7 waits behind a pending load to x7
        vecs.push_back(mkVec(0, 0, 0, 1, 7, LW, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 7, 32'h77, 0, 0, 0, 0, 1, 32'h0000_0707, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 1, 7, 32'h0000_0707, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 1, 7, 32'h0000_0077, 0));
        // Writes to x0 are consumed silently
        vecs.push_back(mkVec(0, 0, 0, 1, 0, LW, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idleVec(0, 0));
        vecs.push_back(mkVec(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idleVec(0, 0));
        // Orphan responses, including issue in the same cycle
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(idleVec(0, 0));
        vecs.push_back(mkVec(0, 0, 0, 1, 8, LW, 0, 1, 32'h99, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 1, 0, 0, 1, 8, 32'h0000_0088, 0));

        reset = 1'b1;
        applyStimulus(idleVec(0, 0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset.wr_en", {31'b0, wrEn}, 32'd0);
        checkOutput("reset.wr_addr", {27'b0, wrAddr}, 32'd0);
        checkOutput("reset.wr_data", wrData, 32'd0);
        checkOutput("reset.rsp_orphan", {31'b0, rspOrphan}, 32'd0);
        checkOutput("reset.ld_ready", {31'b0, ldReady}, 32'd1);
        checkOutput("reset.fwd_data", fwdData, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
`ifdef RF_WB_BYPASS_EN
            eBusy1 = vecs[i].eQ1;
            eBusy2 = vecs[i].eQ2;
            eFwd1  = vecs[i].eWrEn && vecs[i].eWrAddr == vecs[i].rs1 && vecs[i].rs1 != 0;
            eFwd2  = vecs[i].eWrEn && vecs[i].eWrAddr == vecs[i].rs2 && vecs[i].rs2 != 0;
            if (eFwd1 || eFwd2) checkOutput($sformatf("v%0d.fwd_data", i), fwdData, vecs[i].eWrData);
`else
            eBusy1 = vecs[i].eQ1 || (vecs[i].eWrEn && vecs[i].eWrAddr == vecs[i].rs1 && vecs[i].rs1 != 0);
            eBusy2 = vecs[i].eQ2 || (vecs[i].eWrEn && vecs[i].eWrAddr == vecs[i].rs2 && vecs[i].rs2 != 0);
            eFwd1  = 1'b0;
            eFwd2  = 1'b0;
            checkOutput($sformatf("v%0d.fwd_data", i), fwdData, 32'd0);
`endif
            checkOutput($sformatf("v%0d.ld_ready", i), {31'b0, ldReady}, {31'b0, vecs[i].eLdRdy});
            checkOutput($sformatf("v%0d.alu_ready", i), {31'b0, aluReady}, {31'b0, vecs[i].eAluRdy});
            checkOutput($sformatf("v%0d.rs1_busy", i), {31'b0, rs1Busy}, {31'b0, eBusy1});
            checkOutput($sformatf("v%0d.rs2_busy", i), {31'b0, rs2Busy}, {31'b0, eBusy2});
            checkOutput($sformatf("v%0d.rs1_fwd", i), {31'b0, rs1Fwd}, {31'b0, eFwd1});
            checkOutput($sformatf("v%0d.rs2_fwd", i), {31'b0, rs2Fwd}, {31'b0, eFwd2});
            checkOutput($sformatf("v%0d.wr_en", i), {31'b0, wrEn}, {31'b0, vecs[i].eWrEn});
            checkOutput($sformatf("v%0d.rsp_orphan", i), {31'b0, rspOrphan}, {31'b0, vecs[i].eOrph});
            if (vecs[i].eWrEn) begin
                checkOutput($sformatf("v%0d.wr_addr", i), {27'b0, wrAddr}, {27'b0, vecs[i].eWrAddr});
                checkOutput($sformatf("v%0d.wr_data", i), wrData, vecs[i].eWrData);
            end
            @(posedge clock);
            #1;
        end

        // Reset with two loads pending flushes them; later responses are orphans.
        applyStimulus(mkVec(0, 0, 0, 1, 20, LW, 0, 0, 0, 20, 21, 1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        applyStimulus(mkVec(0, 0, 0, 1, 21, LH, 0, 0, 0, 20, 21, 1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        applyStimulus(idleVec(20, 21));
        @(negedge clock);
        checkOutput("flush.pre_rs1_busy", {31'b0, rs1Busy}, 32'd1);
        checkOutput("flush.pre_rs2_busy", {31'b0, rs2Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("flush.rs1_busy", {31'b0, rs1Busy}, 32'd0);
        checkOutput("flush.rs2_busy", {31'b0, rs2Busy}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h5, 20, 21, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        checkOutput("flush.rsp_orphan_early", {31'b0, rspOrphan}, 32'd0);
        @(posedge clock); #1;
        applyStimulus(idleVec(20, 21));
        @(negedge clock);
        checkOutput("flush.rsp_orphan", {31'b0, rspOrphan}, 32'd1);
        checkOutput("flush.wr_en", {31'b0, wrEn}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("flush.rsp_orphan_clear", {31'b0, rspOrphan}, 32'd0);
        checkOutput("flush.wr_en_after", {31'b0, wrEn}, 32'd0);
        @(posedge clock); #1;

        // Value sitting in the write-port register: forwarded or reported busy.
        applyStimulus(mkVec(0, 0, 0, 1, 9, LW, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        applyStimulus(idleVec(9, 9));
        @(negedge clock);
        checkOutput("fwd.wr_en", {31'b0, wrEn}, 32'd1);
        checkOutput("fwd.wr_addr", {27'b0, wrAddr}, 32'd9);
        checkOutput("fwd.wr_data", wrData, 32'hDEAD_BEEF);
`ifdef RF_WB_BYPASS_EN
        checkOutput("fwd.rs2_fwd", {31'b0, rs2Fwd}, 32'd1);
        checkOutput("fwd.rs1_fwd", {31'b0, rs1Fwd}, 32'd1);
        checkOutput("fwd.fwd_data", fwdData, 32'hDEAD_BEEF);
        checkOutput("fwd.rs2_busy", {31'b0, rs2Busy}, 32'd0);
`else
        checkOutput("fwd.rs2_fwd", {31'b0, rs2Fwd}, 32'd0);
        checkOutput("fwd.rs1_fwd", {31'b0, rs1Fwd}, 32'd0);
        checkOutput("fwd.fwd_data", fwdData, 32'd0);
        checkOutput("fwd.rs2_busy", {31'b0, rs2Busy}, 32'd1);
`endif
        @(posedge clock); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
